fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction fetch controller between the core and the byte-organised 64-byte instruction memory. Issues byte reads sequentially and assembles big-endian 32-bit words: byte at address A is bits [31:24], A+3 is bits [7:0]. Buffers completed words in a small FIFO and hands them to the core over a valid/ready handshake. Handles branch redirects by flushing all buffered and in-flight state.

Parameters:
ADDR_W, 6, byte address width; memory size is 2**ADDR_W bytes.
DEPTH, 2, FIFO entries, each holding one instruction word plus its PC; minimum 1.
LAST_PC, 60, highest word-aligned PC; the next PC after LAST_PC wraps to 0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
mem_rd  out  1  byte read strobe to the instruction memory.
mem_addr  out  ADDR_W  byte address; valid while mem_rd=1.
mem_rdata  in  8  read data; valid exactly one cycle after the cycle mem_rd=1 was presented.
redirect  in  1  branch taken; one-cycle pulse.
redirect_pc  in  ADDR_W  new PC; bits [1:0] are ignored and treated as 00.
inst_valid  out  1  FIFO head is valid.
inst_ready  in  1  core accepts the head this cycle.
inst  out  32  head instruction word.
inst_pc  out  ADDR_W  byte address of the head word.
busy  out  1  a word fetch is in flight.

Behaviour:
- Reset (asynchronous, any state): fetch_pc=0, byte index=0, state=IDLE, FIFO empty, read-data-pending flag=0.
  - Output values during reset: mem_rd=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, busy=0.
- State machine states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE when credit is available.
  - credit = (registered FIFO count + in-flight words) < DEPTH.
  - A pop in the same cycle does not create credit in that cycle.
- ISSUE runs for 4 cycles with byte index b=0..3.
  - Each cycle: mem_rd=1 and mem_addr=fetch_pc+b.
  - Each returned byte is written into its assembly-register slot one cycle later.
- After b=3: state -> DRAIN for one cycle while the last byte returns.
  - On that cycle's edge, push {fetch_pc, word} into the FIFO.
  - fetch_pc <= (fetch_pc==LAST_PC) ? 0 : fetch_pc+4.
  - Next state: ISSUE if credit is available (the just-pushed word counts), otherwise IDLE.
- Latency: the first mem_rd comes in the first cycle after reset deasserts, at address 0. inst_valid rises 5 cycles after the first issue cycle.
- Steady-state throughput with inst_ready held high: one word per 5 cycles.
- busy=1 in ISSUE and DRAIN.
- Pop occurs when inst_valid && inst_ready: the head advances and the count decrements. Simultaneous push and pop is legal; the count is unchanged.
- inst and inst_pc are driven from the FIFO head; both are 0 when empty.
- Redirect has priority over everything except reset. On the edge where redirect=1:
  - FIFO is flushed.
  - The pending returning byte is discarded, and the partially assembled word is discarded.
  - A concurrent pop is void; the core must not consume the head on a redirect cycle.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; b <= 0; state <= ISSUE.
  - Result: first fetch of the new PC in the next cycle, inst_valid=0 the next cycle, and the first redirected word is valid 5 cycles after its first issue.
- A redirect arriving during DRAIN cancels that cycle's push.
- Back-to-back redirects: the later one wins; each restarts the fetch.
- Wrap-around: PC 60 -> 0 with no gap cycle. The byte address never exceeds 63.
- mem_rdata is sampled only when the pending flag is set; it is ignored otherwise.

Test Plan:
- Reset release, memory preloaded with bytes 0..63 = value equal to address, inst_ready=1 -> mem_addr sequence 0,1,2,3,4,...; first inst_valid 5 cycles after first mem_rd with inst=32'h00010203, inst_pc=0; next word 32'h04050607, inst_pc=4.
- inst_ready=0 with DEPTH=2 -> exactly two words fetched (PC 0, 4); then mem_rd stays 0 and busy=0. Raising inst_ready -> pop on the same edge; the third fetch (PC 8) starts the following cycle.
- redirect=1 with redirect_pc=6'd23 while in ISSUE at b=2 -> next cycle inst_valid=0 and mem_addr=20, 21, 22, 23; the stale byte is dropped; the first word is inst_pc=20, inst=32'h14151617.
- Start at PC 56 with inst_ready=1 -> words at inst_pc 56, 60, 0 delivered with no dropped or duplicated word; mem_addr never exceeds 63.
- Assert reset mid-DRAIN with the FIFO holding one word -> all outputs 0 immediately (asynchronously). After release, fetching restarts at address 0.
- redirect and inst_ready both high with inst_valid=1 -> FIFO count becomes 0; the next valid word carries the redirected PC.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: byte-wide instruction memory read port, redirect input
// and the instruction handoff to the core.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              busy;

  // Handshake: a word transfers on a rising edge where inst_valid && inst_ready
  // are both high; inst_valid does not depend on inst_ready, and a transfer is
  // void on any edge where redirect is also high.
  modport master (
    output mem_rd, mem_addr, inst_valid, inst, inst_pc, busy,
    input  mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_rd, mem_addr, inst_valid, inst, inst_pc, busy,
    output mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues four byte reads per word, assembles a
// big-endian word, buffers {pc, word} in a small FIFO and flushes on redirect.
module fetch_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 2,
  parameter int LAST_PC = 60
) (
  input  logic              clk,
  input  logic              reset,
  fetch_ctrl_if.master      bus,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_PC_C = ADDR_W'(LAST_PC);

  state_t            state_q;
  logic [1:0]        b_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pend_q;
  logic [1:0]        pend_idx_q;
  logic [23:0]       asm_q;
  logic [31:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] wpc_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic              credit_idle;
  logic              credit_drain;
  logic [CNT_W:0]    cnt_plus1;
  logic [31:0]       push_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign issue     = (state_q == S_ISSUE);
  assign push      = (state_q == S_DRAIN);
  assign pop       = bus.inst_valid && bus.inst_ready;
  assign push_word = {asm_q, bus.mem_rdata};

  // In-flight words only exist outside IDLE, so IDLE checks the count alone and
  // DRAIN counts the word it is pushing; a same-cycle pop never adds credit.
  assign cnt_plus1    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign credit_idle  = cnt_q < CNT_W'(DEPTH);
  assign credit_drain = cnt_plus1 < (CNT_W + 1)'(DEPTH);

  assign bus.mem_rd     = issue;
  assign bus.mem_addr   = issue ? (pc_q + {{(ADDR_W-2){1'b0}}, b_q}) : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.inst_valid = (cnt_q != '0);
  assign bus.inst       = bus.inst_valid ? word_q[rd_ptr_q] : '0;
  assign bus.inst_pc    = bus.inst_valid ? wpc_q[rd_ptr_q]  : '0;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      pc_q       <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else if (bus.redirect) begin
      state_q    <= S_ISSUE;
      b_q        <= '0;
      pc_q       <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      pend_q     <= issue;
      pend_idx_q <= b_q;

      // Byte 3 bypasses the assembly register and goes straight into the FIFO.
      if (pend_q) begin
        case (pend_idx_q)
          2'd0:    asm_q[23:16] <= bus.mem_rdata;
          2'd1:    asm_q[15:8]  <= bus.mem_rdata;
          2'd2:    asm_q[7:0]   <= bus.mem_rdata;
          default: ;
        endcase
      end

      if (push) begin
        word_q[wr_ptr_q] <= push_word;
        wpc_q[wr_ptr_q]  <= pc_q;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase

      case (state_q)
        S_IDLE: begin
          if (credit_idle) begin
            state_q <= S_ISSUE;
            b_q     <= '0;
          end
        end
        S_ISSUE: begin
          b_q <= b_q + 2'd1;
          if (b_q == 2'd3) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          pc_q    <= (pc_q == LAST_PC_C) ? '0 : pc_q + ADDR_W'(4);
          b_q     <= '0;
          state_q <= credit_drain ? S_ISSUE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
